// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } arb_state_t;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates a single memory port between an instruction-fetch requester
// (read-only) and a data requester (read/write). One owner holds the port
// from grant until mem_resp or until it drops its request.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int BE_WIDTH   = DATA_WIDTH / 8,
  parameter int D_PRIORITY = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_read,
  input  logic [ADDR_WIDTH-1:0] i_address,
  output logic [DATA_WIDTH-1:0] i_rdata,
  output logic                  i_resp,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [BE_WIDTH-1:0]   d_byte_enable,
  input  logic [ADDR_WIDTH-1:0] d_address,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_resp,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [BE_WIDTH-1:0]   mem_byte_enable,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_resp
);

  arb_state_t state, next_state;
  logic       last_grant, next_last_grant;
  logic       i_req, d_req;

  assign i_req = i_read;
  assign d_req = d_read | d_write;

  // Read data is broadcast to both sides; only the resp strobes are steered.
  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;

  // State and last-grant registers; last_grant starts at D so I wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= GRANT_D;
    end else begin
      state      <= next_state;
      last_grant <= next_last_grant;
    end
  end

  // Next-state: grant from IDLE, return to IDLE on completion or owner abort.
  always_comb begin
    next_state      = state;
    next_last_grant = last_grant;
    case (state)
      IDLE: begin
        if (i_req && d_req) begin
          if ((D_PRIORITY != 0) || (last_grant == GRANT_I)) next_state = SERVE_D;
          else                                              next_state = SERVE_I;
        end else if (i_req) begin
          next_state = SERVE_I;
        end else if (d_req) begin
          next_state = SERVE_D;
        end
      end
      SERVE_I: begin
        if (mem_resp) begin
          next_state      = IDLE;
          next_last_grant = GRANT_I;
        end else if (!i_req) begin
          next_state = IDLE;
        end
      end
      SERVE_D: begin
        if (mem_resp) begin
          next_state      = IDLE;
          next_last_grant = GRANT_D;
        end else if (!d_req) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Port mux: the owner's request drives the memory combinationally; reset forces everything quiet.
  always_comb begin
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    mem_byte_enable = '0;
    mem_address     = '0;
    mem_wdata       = '0;
    i_resp          = 1'b0;
    d_resp          = 1'b0;
    if (!rst) begin
      case (state)
        SERVE_I: begin
          mem_read        = i_read;
          mem_address     = i_address;
          mem_byte_enable = '1;
          i_resp          = mem_resp;
        end
        SERVE_D: begin
          mem_read        = d_read;
          mem_write       = d_write;
          mem_address     = d_address;
          mem_byte_enable = d_byte_enable;
          mem_wdata       = d_wdata;
          d_resp          = mem_resp;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a round-robin instance with a 3-cycle
// memory model and a D-priority instance with a 1-cycle memory model.
module tb_mem_arbiter;

  localparam int MEM_LAT = 3;

  logic clk = 1'b0;
  logic rst;

  // Round-robin instance signals
  logic        i_read, d_read, d_write;
  logic [15:0] i_address, d_address, d_wdata;
  logic [1:0]  d_byte_enable;
  logic [15:0] i_rdata, d_rdata;
  logic        i_resp, d_resp;
  logic        mem_read, mem_write;
  logic [1:0]  mem_byte_enable;
  logic [15:0] mem_address, mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_resp;

  // D-priority instance signals
  logic        p_i_read, p_d_read;
  logic [15:0] p_i_rdata, p_d_rdata;
  logic        p_i_resp, p_d_resp;
  logic        p_mem_read, p_mem_write;
  logic [1:0]  p_mem_byte_enable;
  logic [15:0] p_mem_address, p_mem_wdata;
  logic        p_mem_resp;
  logic [15:0] p_mem_rdata;

  // Memory model state
  logic [15:0] mem_array [0:511];
  int          lat_cnt;

  // Monitors
  int i_cnt = 0, d_cnt = 0, p_i_cnt = 0, p_d_cnt = 0;
  int bubble_bad = 0, both_resp = 0;
  bit prev_resp = 1'b0;
  bit order [$];

  int errors = 0;
  int checks = 0;
  int cycles;
  int start_idx, i_snap, d_snap, p_i_snap;

  assign p_mem_rdata = 16'h5555;

  mem_arbiter #(.D_PRIORITY(0)) u_dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_byte_enable(d_byte_enable),
    .d_address(d_address), .d_wdata(d_wdata), .d_rdata(d_rdata), .d_resp(d_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_byte_enable(mem_byte_enable),
    .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  mem_arbiter #(.D_PRIORITY(1)) u_dut_p (
    .clk(clk), .rst(rst),
    .i_read(p_i_read), .i_address(16'h0040), .i_rdata(p_i_rdata), .i_resp(p_i_resp),
    .d_read(p_d_read), .d_write(1'b0), .d_byte_enable(2'b11),
    .d_address(16'h0100), .d_wdata(16'h0000), .d_rdata(p_d_rdata), .d_resp(p_d_resp),
    .mem_read(p_mem_read), .mem_write(p_mem_write), .mem_byte_enable(p_mem_byte_enable),
    .mem_address(p_mem_address), .mem_wdata(p_mem_wdata),
    .mem_rdata(p_mem_rdata), .mem_resp(p_mem_resp)
  );

  always #5 clk = ~clk;

  // Memory with fixed latency: responds after MEM_LAT cycles of a held strobe, resp lasts one cycle.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_resp        <= 1'b0;
      lat_cnt         <= 0;
      mem_rdata       <= 16'h0000;
      mem_array[64]   <= 16'h1234;
      mem_array[256]  <= 16'h7788;
    end else if (mem_resp) begin
      mem_resp <= 1'b0;
      lat_cnt  <= 0;
    end else if (mem_read || mem_write) begin
      if (lat_cnt == MEM_LAT - 1) begin
        mem_resp  <= 1'b1;
        lat_cnt   <= 0;
        mem_rdata <= mem_array[mem_address[8:0]];
        if (mem_write) begin
          if (mem_byte_enable[0]) mem_array[mem_address[8:0]][7:0]  <= mem_wdata[7:0];
          if (mem_byte_enable[1]) mem_array[mem_address[8:0]][15:8] <= mem_wdata[15:8];
        end
      end else begin
        lat_cnt <= lat_cnt + 1;
      end
    end else begin
      lat_cnt <= 0;
    end
  end

  // Single-cycle-latency memory for the priority instance.
  always @(posedge clk or posedge rst) begin
    if (rst) p_mem_resp <= 1'b0;
    else     p_mem_resp <= (p_mem_read || p_mem_write) && !p_mem_resp;
  end

  // Mid-cycle monitor: response counts, grant order, bubble after completion, exclusive resp.
  always @(negedge clk) begin
    if (i_resp) begin i_cnt++; order.push_back(1'b0); end
    if (d_resp) begin d_cnt++; order.push_back(1'b1); end
    if (i_resp && d_resp) both_resp++;
    if (prev_resp && (mem_read || mem_write)) bubble_bad++;
    prev_resp = i_resp | d_resp;
    if (p_i_resp) p_i_cnt++;
    if (p_d_resp) p_d_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic ir, input logic [15:0] ia, input logic dr, input logic dw,
                               input logic [1:0] dbe, input logic [15:0] da, input logic [15:0] dwd);
    i_read        = ir;
    i_address     = ia;
    d_read        = dr;
    d_write       = dw;
    d_byte_enable = dbe;
    d_address     = da;
    d_wdata       = dwd;
  endtask

  // which: 0 = I resp, 1 = D resp, 2 = priority-instance I resp
  task automatic waitResp(input string tag, input int which, input int budget, output int n);
    bit found;
    found = 1'b0;
    n     = 0;
    while (!found && n < budget) begin
      tick();
      n++;
      case (which)
        0:       found = i_resp;
        1:       found = d_resp;
        default: found = p_i_resp;
      endcase
    end
    checkOutput({tag, "_resp_seen"}, {31'd0, found}, 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    p_i_read = 1'b0;
    p_d_read = 1'b0;
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000);
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    checkOutput("rst_mem_read", {31'd0, mem_read}, 32'd0);
    checkOutput("rst_mem_write", {31'd0, mem_write}, 32'd0);
    checkOutput("rst_mem_be", {30'd0, mem_byte_enable}, 32'd0);
    checkOutput("rst_resp", {30'd0, i_resp, d_resp}, 32'd0);
    rst = 1'b0;
    tick();

    // I-only read of 0x0040 holding 0x1234
    applyStimulus(1'b1, 16'h0040, 1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000);
    i_snap = i_cnt;
    d_snap = d_cnt;
    checkOutput("i_grant_latency", {31'd0, mem_read}, 32'd0);
    tick();
    checkOutput("i_mem_read", {31'd0, mem_read}, 32'd1);
    checkOutput("i_mem_addr", {16'd0, mem_address}, 32'h0040);
    checkOutput("i_mem_be", {30'd0, mem_byte_enable}, 32'h3);
    checkOutput("i_mem_write", {31'd0, mem_write}, 32'd0);
    waitResp("i_only", 0, 10, cycles);
    checkOutput("i_latency", cycles, 32'd3);
    checkOutput("i_rdata", {16'd0, i_rdata}, 32'h1234);
    applyStimulus(1'b0, 16'h0040, 1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000);
    tick();
    checkOutput("i_bubble_read", {31'd0, mem_read}, 32'd0);
    checkOutput("i_resp_count", i_cnt - i_snap, 32'd1);
    checkOutput("i_no_d_resp", d_cnt - d_snap, 32'd0);

    // D write, low byte only
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1, 2'b01, 16'h0100, 16'hABCD);
    d_snap = d_cnt;
    tick();
    checkOutput("d_mem_write", {31'd0, mem_write}, 32'd1);
    checkOutput("d_mem_read", {31'd0, mem_read}, 32'd0);
    checkOutput("d_mem_be", {30'd0, mem_byte_enable}, 32'h1);
    checkOutput("d_mem_addr", {16'd0, mem_address}, 32'h0100);
    checkOutput("d_mem_wdata", {16'd0, mem_wdata}, 32'hABCD);
    waitResp("d_write", 1, 10, cycles);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000);
    tick();
    checkOutput("d_mem_contents", {16'd0, mem_array[256]}, 32'h77CD);
    checkOutput("d_resp_count", d_cnt - d_snap, 32'd1);

    // Round-robin tie from reset: expect I, D, I
    rst = 1'b1;
    tick();
    rst = 1'b0;
    applyStimulus(1'b1, 16'h0040, 1'b1, 1'b0, 2'b11, 16'h0100, 16'h0000);
    start_idx = order.size();
    cycles = 0;
    while (order.size() < start_idx + 3 && cycles < 80) begin
      tick();
      cycles++;
    end
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000);
    checkOutput("tie_done", {31'd0, order.size() >= start_idx + 3}, 32'd1);
    if (order.size() >= start_idx + 3) begin
      checkOutput("tie_first", {31'd0, order[start_idx]}, 32'd0);
      checkOutput("tie_second", {31'd0, order[start_idx + 1]}, 32'd1);
      checkOutput("tie_third", {31'd0, order[start_idx + 2]}, 32'd0);
    end
    tick();
    tick();
    checkOutput("bubble_after_resp", bubble_bad, 32'd0);
    checkOutput("exclusive_resp", both_resp, 32'd0);

    // D priority: D wins three times, I starves, then I is served
    p_i_read = 1'b1;
    p_d_read = 1'b1;
    i_snap   = p_i_cnt;
    d_snap   = p_d_cnt;
    cycles   = 0;
    while (p_d_cnt < d_snap + 3 && cycles < 40) begin
      tick();
      cycles++;
    end
    checkOutput("prio_d_count", p_d_cnt - d_snap, 32'd3);
    checkOutput("prio_i_starved", p_i_cnt - i_snap, 32'd0);
    p_d_read = 1'b0;
    waitResp("prio_i_after", 2, 10, cycles);
    checkOutput("prio_i_addr", {16'd0, p_mem_address}, 32'h0040);
    p_i_read = 1'b0;
    tick();

    // Abort: D read dropped before mem_resp, pending I is granted next
    applyStimulus(1'b0, 16'h0040, 1'b1, 1'b0, 2'b11, 16'h0100, 16'h0000);
    d_snap = d_cnt;
    tick();
    checkOutput("abort_grant_d", {31'd0, mem_read}, 32'd1);
    tick();
    applyStimulus(1'b1, 16'h0040, 1'b0, 1'b0, 2'b11, 16'h0100, 16'h0000);
    #1;
    checkOutput("abort_strobe_drop", {31'd0, mem_read}, 32'd0);
    tick();
    checkOutput("abort_idle_read", {31'd0, mem_read}, 32'd0);
    tick();
    checkOutput("abort_i_granted", {31'd0, mem_read}, 32'd1);
    checkOutput("abort_i_addr", {16'd0, mem_address}, 32'h0040);
    waitResp("abort_i", 0, 10, cycles);
    checkOutput("abort_i_latency", cycles, 32'd3);
    checkOutput("abort_no_d_resp", d_cnt - d_snap, 32'd0);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000);
    tick();

    // Reset mid-transaction, then the first tie goes to I
    applyStimulus(1'b1, 16'h0040, 1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000);
    tick();
    checkOutput("rstmid_pre_read", {31'd0, mem_read}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rstmid_read", {31'd0, mem_read}, 32'd0);
    checkOutput("rstmid_resp", {31'd0, i_resp}, 32'd0);
    checkOutput("rstmid_addr", {16'd0, mem_address}, 32'h0000);
    tick();
    rst = 1'b0;
    applyStimulus(1'b1, 16'h0040, 1'b1, 1'b0, 2'b11, 16'h0100, 16'h0000);
    checkOutput("rstmid_idle", {31'd0, mem_read}, 32'd0);
    tick();
    checkOutput("rstmid_tie_addr", {16'd0, mem_address}, 32'h0040);
    checkOutput("rstmid_tie_read", {31'd0, mem_read}, 32'd1);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000);
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
